wptr_full_gen: RTL and testbench

Write-side pointer and full-flag generator for the asynchronous FIFO. It sits directly upstream of the FIFO storage array in the wclk domain. It owns the binary write pointer, which drives the array's write address. It also produces the Gray-coded write pointer for the read domain, and derives full, almost_full and a sticky overflow flag by comparing against the read-domain Gray pointer synchronised into wclk.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/wptr_full_gen.sv | 64 ++++++
 tb/tb_wptr_full_gen.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer types and Gray-code helpers for both FIFO clock domains
package fifo_pkg;

    localparam int DEF_PTR_WIDTH = 8;
    localparam int DEF_DEPTH     = 2 ** DEF_PTR_WIDTH;

    typedef logic [DEF_PTR_WIDTH:0] ptr_t;

    // Operate on a 32-bit container so any pointer width up to 32 can zero-extend in and truncate out.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a Gray-coded bus crossing into the local clock domain
module sync_2ff #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1;

    // Two back-to-back flops with nothing in between to give metastability time to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/wptr_full_gen.sv
// wptr_full_gen: write pointer, Gray pointer and full/almost_full/overflow flags for the async FIFO
module wptr_full_gen
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH = DEF_PTR_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_MARGIN = 4
) (
    input  logic               wclk,
    input  logic               w_rst_n,
    input  logic               w_en,
    input  logic [PTR_WIDTH:0] g_rptr,
    output logic [PTR_WIDTH:0] waddr,
    output logic [PTR_WIDTH:0] g_wptr,
    output logic               full,
    output logic               almost_full,
    output logic               overflow
);

    localparam int PW = PTR_WIDTH + 1;

    logic [PTR_WIDTH:0] rq2;
    logic [PTR_WIDTH:0] b_next;
    logic [PTR_WIDTH:0] g_next;
    logic [PTR_WIDTH:0] r_bin;
    logic [PTR_WIDTH:0] lvl;
    logic               full_next;
    logic               af_next;

    sync_2ff #(.WIDTH(PW)) u_rptr_sync (
        .clk   (wclk),
        .rst_n (w_rst_n),
        .d     (g_rptr),
        .q     (rq2)
    );

    // Next pointer and flag terms; full compares Gray codes directly, level uses the decoded read pointer.
    always_comb begin
        b_next    = waddr + PW'(w_en & ~full);
        g_next    = PW'(bin2gray(32'(b_next)));
        r_bin     = PW'(gray2bin(32'(rq2)));
        lvl       = b_next - r_bin;
        full_next = (g_next == {~rq2[PTR_WIDTH:PTR_WIDTH-1], rq2[PTR_WIDTH-2:0]});
        af_next   = (lvl >= PW'(DEPTH - AF_MARGIN));
    end

    // Register pointers and flags; overflow latches any write attempted while full.
    always_ff @(posedge wclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            waddr       <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            waddr       <= b_next;
            g_wptr      <= g_next;
            full        <= full_next;
            almost_full <= af_next;
            overflow    <= overflow | (w_en & full);
        end
    end

endmodule

// File: tb/tb_wptr_full_gen.sv
// tb_wptr_full_gen: scoreboard bench for the write pointer / full flag generator
module tb_wptr_full_gen;

    localparam int D   = 256;
    localparam int AFM = 4;

    typedef struct {
        logic [8:0] wa;
        logic [8:0] g;
        logic       f;
        logic       af;
        logic       ov;
    } exp_t;

    logic       wclk = 1'b0;
    logic       w_rst_n = 1'b1;
    logic       w_en = 1'b0;
    logic [8:0] g_rptr = '0;
    logic [8:0] waddr;
    logic [8:0] g_wptr;
    logic       full;
    logic       almost_full;
    logic       overflow;

    int checks = 0;
    int failures = 0;

    exp_t       sbq[$];
    logic [8:0] mw, ms1, ms2;
    logic       mf, maf, mov;

    always #5 wclk = ~wclk;

    wptr_full_gen #(.PTR_WIDTH(8), .DEPTH(D), .AF_MARGIN(AFM)) dut (
        .wclk        (wclk),
        .w_rst_n     (w_rst_n),
        .w_en        (w_en),
        .g_rptr      (g_rptr),
        .waddr       (waddr),
        .g_wptr      (g_wptr),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] b2g(input logic [8:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [8:0] g2b(input logic [8:0] g);
        logic [8:0] b;
        b[8] = g[8];
        for (int i = 7; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic model_reset();
        mw = '0; ms1 = '0; ms2 = '0;
        mf = 1'b0; maf = 1'b0; mov = 1'b0;
        sbq.delete();
    endtask

    task automatic step(input logic en, input logic [8:0] gr);
        logic [8:0] bn, lvl;
        exp_t e;
        @(negedge wclk);
        w_en = en;
        g_rptr = gr;
        bn  = mw + {8'd0, en & ~mf};
        lvl = bn - g2b(ms2);
        mov = mov | (en & mf);
        mf  = (lvl == 9'(D));
        maf = (lvl >= 9'(D - AFM));
        ms2 = ms1;
        ms1 = gr;
        mw  = bn;
        sbq.push_back('{bn, b2g(bn), mf, maf, mov});
        @(posedge wclk);
        #1;
        if (sbq.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            check("waddr", 32'(waddr), 32'(e.wa));
            check("g_wptr", 32'(g_wptr), 32'(e.g));
            check("full", 32'(full), 32'(e.f));
            check("almost_full", 32'(almost_full), 32'(e.af));
            check("overflow", 32'(overflow), 32'(e.ov));
        end
    endtask

    task automatic do_reset();
        @(posedge wclk);
        #3;
        w_rst_n = 1'b0;
        w_en = 1'b0;
        g_rptr = '0;
        #1;
        check("rst_waddr", 32'(waddr), 32'h0);
        check("rst_g_wptr", 32'(g_wptr), 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_af", 32'(almost_full), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        model_reset();
        @(negedge wclk);
        @(negedge wclk);
        w_rst_n = 1'b1;
        #1;
        check("post_rst_waddr", 32'(waddr), 32'h000);
        check("post_rst_g_wptr", 32'(g_wptr), 32'h000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] pa, pg;
        int wraps;
        #2;
        w_rst_n = 1'b0;
        do_reset();

        for (int k = 1; k <= 256; k++) begin
            step(1'b1, 9'h000);
            if (k == 251) check("af_before", 32'(almost_full), 32'h0);
            if (k == 252) check("af_at_252", 32'(almost_full), 32'h1);
            if (k == 255) check("full_before", 32'(full), 32'h0);
        end
        check("fill_waddr", 32'(waddr), 32'h100);
        check("fill_g_wptr", 32'(g_wptr), 32'h180);
        check("fill_full", 32'(full), 32'h1);
        check("fill_ovf", 32'(overflow), 32'h0);

        for (int k = 0; k < 3; k++) begin
            step(1'b1, 9'h000);
            check("ovf_waddr_hold", 32'(waddr), 32'h100);
            check("ovf_set", 32'(overflow), 32'h1);
        end
        step(1'b0, 9'h000);
        check("ovf_sticky", 32'(overflow), 32'h1);

        step(1'b0, 9'h001);
        check("rel_edge1_full", 32'(full), 32'h1);
        step(1'b0, 9'h001);
        check("rel_edge2_full", 32'(full), 32'h1);
        step(1'b0, 9'h001);
        check("rel_edge3_full", 32'(full), 32'h0);
        step(1'b1, 9'h001);
        check("rel_write_waddr", 32'(waddr), 32'h101);
        check("rel_refull", 32'(full), 32'h1);

        do_reset();
        for (int k = 0; k < 100; k++) step(1'b1, 9'h000);
        check("burst_waddr", 32'(waddr), 32'd100);
        do_reset();
        step(1'b1, 9'h000);
        check("resume_waddr", 32'(waddr), 32'h001);

        do_reset();
        pa = '0;
        pg = '0;
        wraps = 0;
        for (int k = 0; k < 600; k++) begin
            step(1'b1, b2g(mw));
            check("wrap_no_full", 32'(full), 32'h0);
            check("wrap_hamming", 32'($countones(g_wptr ^ pg)), 32'd1);
            if (pa == 9'h1FF) begin
                wraps++;
                check("wrap_waddr", 32'(waddr), 32'h000);
                check("wrap_g_prev", 32'(pg), 32'h100);
                check("wrap_g_now", 32'(g_wptr), 32'h000);
            end
            pa = waddr;
            pg = g_wptr;
        end
        check("wrap_count", 32'(wraps), 32'd1);
        check("wrap_final_waddr", 32'(waddr), 32'd88);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
